// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches level reset requests into a staged multi-domain
// reset, with an optional delayed re-reset after a ROM download ends.
module reset_sequencer #(
    parameter int          NSRC      = 4,
    parameter int          NOUT      = 2,
    parameter int          PULSE_LEN = 1000,
    parameter int          STAGE_GAP = 16,
    parameter int unsigned REARM_DLY = 5000000
) (
    input  logic            clk_sys,
    input  logic            res_n,
    input  logic            pll_locked,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] req_en,
    input  logic            dl_active,
    input  logic            rearm_en,
    output logic [NOUT-1:0] rst_out,
    output logic            busy,
    output logic [7:0]      evt_cnt
);

    localparam int HW = $clog2(PULSE_LEN + 1);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [HW-1:0] HOLD_INIT = HW'(PULSE_LEN);
    localparam logic [HW-1:0] HOLD_RLD  = HW'(PULSE_LEN - 1);
    localparam logic [GW-1:0] GAP_RLD   = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NOUT - 1);
    localparam logic [31:0]   DLY_RLD   = 32'(REARM_DLY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_STAGE
    } state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_req_q;
    logic            r_lock_q;
    logic            r_dl_q;
    logic            r_dl_qq;
    logic [31:0]     r_timer;
    logic            r_fire;
    logic            r_trig_q;
    logic [7:0]      r_evt;
    logic [HW-1:0]   r_hold;
    logic [GW-1:0]   r_gap;
    logic [IW-1:0]   r_idx;
    logic [NOUT-1:0] r_rst;

    logic w_trig;
    logic w_dl_fall;

    assign w_trig    = (|(r_req_q & req_en)) | ~r_lock_q | r_fire;
    assign w_dl_fall = r_dl_qq & ~r_dl_q;

    assign rst_out = r_rst;
    assign evt_cnt = r_evt;
    assign busy    = (|r_rst) | (r_timer != 32'd0);

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            r_req_q  <= '0;
            r_lock_q <= 1'b0;
            r_dl_q   <= 1'b0;
            r_dl_qq  <= 1'b0;
            r_timer  <= '0;
            r_fire   <= 1'b0;
        end else begin
            r_req_q  <= req;
            r_lock_q <= pll_locked;
            r_dl_q   <= dl_active;
            r_dl_qq  <= r_dl_q;
            r_fire   <= 1'b0;
            // a running download or a disabled rearm cancels the timer
            if (r_dl_q || !rearm_en) begin
                r_timer <= '0;
            end else if (w_dl_fall) begin
                r_timer <= DLY_RLD;
            end else if (r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
                r_fire  <= (r_timer == 32'd1);
            end
        end
    end

    // trig history resets high so the reset-time lock loss is not an event
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            r_trig_q <= 1'b1;
            r_evt    <= '0;
        end else begin
            r_trig_q <= w_trig;
            if (w_trig && !r_trig_q && r_evt != 8'hFF)
                r_evt <= r_evt + 8'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            r_state <= S_HOLD;
            r_hold  <= HOLD_INIT;
            r_gap   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state <= S_HOLD;
                        r_hold  <= HOLD_RLD;
                        r_rst   <= '1;
                    end
                end
                S_HOLD: begin
                    r_rst <= '1;
                    if (w_trig) begin
                        r_hold <= HOLD_RLD;
                    end else if (r_hold == '0) begin
                        // first stage slot acts on the exit edge
                        r_rst[0] <= 1'b0;
                        r_gap    <= GAP_RLD;
                        r_idx    <= (NOUT > 1) ? IW'(1) : '0;
                        r_state  <= (NOUT > 1) ? S_STAGE : S_IDLE;
                    end else begin
                        r_hold <= r_hold - HW'(1);
                    end
                end
                S_STAGE: begin
                    if (w_trig) begin
                        r_state <= S_HOLD;
                        r_hold  <= HOLD_RLD;
                        r_rst   <= '1;
                    end else if (r_gap == '0) begin
                        r_rst[r_idx] <= 1'b0;
                        r_gap        <= GAP_RLD;
                        if (r_idx == IDX_LAST)
                            r_state <= S_IDLE;
                        else
                            r_idx <= r_idx + IW'(1);
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
